lea_block_unpacker: RTL and testbench



---
 rtl/lea_pkg.sv | 18 +
 rtl/lea_block_hold_reg.sv | 23 ++
 rtl/lea_block_unpacker.sv | 97 +++++++++
 tb/tb_lea_block_unpacker.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/lea_pkg.sv
// Shared LEA datapath definitions: block geometry, unpacker FSM states and a
// byte-swap helper used by the LEA_WORD_BSWAP_EN build option.
package lea_pkg;

  localparam int unsigned LEA_BLOCK_W   = 128;
  localparam int unsigned LEA_WORD_W    = 32;
  localparam int unsigned LEA_NUM_WORDS = 4;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } unpack_state_e;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/lea_block_hold_reg.sv
// 128-bit block holding register, split into four 32-bit lanes sharing one
// load enable; asynchronous active-low reset clears every lane.
module lea_block_hold_reg
  import lea_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [LEA_BLOCK_W-1:0] d,
  output logic [LEA_BLOCK_W-1:0] q
);

  for (genvar i = 0; i < LEA_NUM_WORDS; i++) begin : g_lane
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q[i*LEA_WORD_W +: LEA_WORD_W] <= '0;
      end else if (load) begin
        q[i*LEA_WORD_W +: LEA_WORD_W] <= d[i*LEA_WORD_W +: LEA_WORD_W];
      end
    end
  end

endmodule

// File: rtl/lea_block_unpacker.sv
// Serializes one 128-bit LEA block into four 32-bit words over valid/ready.
// Build option: define LEA_WORD_BSWAP_EN to byte-reverse each output word.
module lea_block_unpacker
  import lea_pkg::*;
#(
  parameter int unsigned NUM_WORDS = LEA_NUM_WORDS,
  parameter int unsigned WORD_W    = LEA_WORD_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_WORDS*WORD_W-1:0]   in_block,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WORD_W-1:0]             out_word,
  output logic                          out_last,
  output logic                          busy
);

  localparam logic [1:0] LAST_IDX = 2'(NUM_WORDS - 1);

  unpack_state_e                  state;
  logic [1:0]                     idx;
  logic                           load;
  logic [NUM_WORDS*WORD_W-1:0]    hold_q;
  logic [WORD_W-1:0]              words [NUM_WORDS];
  logic [WORD_W-1:0]              sel_word;

  // Accepting a new block is allowed on the same edge as the final word handshake.
  assign in_ready = (state == ST_IDLE) || ((idx == LAST_IDX) && out_ready);
  assign load     = in_valid && in_ready;
  assign busy     = (state == ST_SEND);

  lea_block_hold_reg u_hold (
    .clk   (clk),
    .rst_n (rst),
    .load  (load),
    .d     (in_block),
    .q     (hold_q)
  );

  always_comb begin
    for (int unsigned i = 0; i < NUM_WORDS; i++) begin
      words[i] = hold_q[i*WORD_W +: WORD_W];
    end
    sel_word = words[idx];
  end

`ifdef LEA_WORD_BSWAP_EN
  assign out_word = bswap32(sel_word);
`else
  assign out_word = sel_word;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            state     <= ST_SEND;
            idx       <= '0;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
          end
        end
        ST_SEND: begin
          if (out_ready) begin
            if (idx == LAST_IDX) begin
              idx      <= '0;
              out_last <= 1'b0;
              if (!in_valid) begin
                state     <= ST_IDLE;
                out_valid <= 1'b0;
              end
            end else begin
              idx      <= idx + 2'd1;
              out_last <= (idx == LAST_IDX - 2'd1);
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          idx       <= '0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lea_block_unpacker.sv
// Directed bench for lea_block_unpacker: reset, single block, backpressure,
// back-to-back blocks and reset mid-stream.
module tb_lea_block_unpacker;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_block;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_word;
  logic         out_last;
  logic         busy;

  int unsigned n_tests;
  int unsigned n_fail;

  localparam logic [127:0] BLK_A = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] BLK_B = 128'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC;
  localparam logic [127:0] BLK_J = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

  logic [31:0] exp_a [4];
  logic [31:0] exp_b [4];

  lea_block_unpacker dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_word(input string tag, input logic [31:0] w, input logic last);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".word"},  out_word, w);
    check({tag, ".last"},  32'(out_last), 32'(last));
    check({tag, ".busy"},  32'(busy), 32'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".valid"},    32'(out_valid), 32'd0);
    check({tag, ".busy"},     32'(busy), 32'd0);
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    check({tag, ".last"},     32'(out_last), 32'd0);
  endtask

  initial begin
`ifdef LEA_WORD_BSWAP_EN
    exp_a[0] = 32'h00010203; exp_a[1] = 32'h04050607;
    exp_a[2] = 32'h08090A0B; exp_a[3] = 32'h0C0D0E0F;
`else
    exp_a[0] = 32'h03020100; exp_a[1] = 32'h07060504;
    exp_a[2] = 32'h0B0A0908; exp_a[3] = 32'h0F0E0D0C;
`endif
    exp_b[0] = 32'hCCCCCCCC; exp_b[1] = 32'hDDDDDDDD;
    exp_b[2] = 32'hEEEEEEEE; exp_b[3] = 32'hFFFFFFFF;

    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_block  = '0;
    out_ready = 1'b1;

    #2;
    check_idle("reset");
    check("reset.word", out_word, 32'h0);
    step();
    step();
    rst = 1'b1;
    step();
    check_idle("post_reset");

    // Single block, sink always ready
    in_valid = 1'b1;
    in_block = BLK_A;
    step();
    in_valid = 1'b0;
    in_block = '0;
    check_word("single.w0", exp_a[0], 1'b0);
    check("single.w0.in_ready", 32'(in_ready), 32'd0);
    for (int k = 1; k < 4; k++) begin
      step();
      check_word($sformatf("single.w%0d", k), exp_a[k], k == 3);
      check($sformatf("single.w%0d.in_ready", k), 32'(in_ready), (k == 3) ? 32'd1 : 32'd0);
    end
    step();
    check_idle("single.done");

    // Backpressure on word 1; junk block offered while in_ready is low
    in_valid = 1'b1;
    in_block = BLK_A;
    step();
    in_valid = 1'b0;
    check_word("bp.w0", exp_a[0], 1'b0);
    step();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_block  = BLK_J;
    for (int k = 0; k < 3; k++) begin
      check_word($sformatf("bp.stall%0d", k), exp_a[1], 1'b0);
      check($sformatf("bp.stall%0d.in_ready", k), 32'(in_ready), 32'd0);
      step();
    end
    check_word("bp.stall3", exp_a[1], 1'b0);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    step();
    check_word("bp.w2", exp_a[2], 1'b0);
    step();
    check_word("bp.w3", exp_a[3], 1'b1);

    // Back-to-back: next block offered during the last word
    in_valid = 1'b1;
    in_block = BLK_B;
    check("b2b.in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    in_block = '0;
    for (int k = 0; k < 4; k++) begin
      check_word($sformatf("b2b.w%0d", k), exp_b[k], k == 3);
      step();
    end
    check_idle("b2b.done");

    // Reset mid-block
    in_valid = 1'b1;
    in_block = BLK_A;
    step();
    in_valid = 1'b0;
    step();
    check_word("mid.w1", exp_a[1], 1'b0);
    rst = 1'b0;
    #1;
    check_idle("mid.rst");
    step();
    check_idle("mid.rst_hold");
    rst = 1'b1;
    step();
    check_idle("mid.release");
    in_valid = 1'b1;
    in_block = BLK_B;
    step();
    in_valid = 1'b0;
    check_word("mid.new.w0", exp_b[0], 1'b0);
    step();
    check_word("mid.new.w1", exp_b[1], 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
